rom_burst_reader: RTL and testbench

- Parametrised successor to the single-byte ROM fetch engine. It reads an external parallel ROM whose address is multiplexed onto the shared data/address bus through external transparent latches.
- Accepts a start address and burst length over a valid/ready request port. It sequences latch strobes and access-time waits, then streams one data word per beat to the cartridge/loader logic.
- Generalised in address width, bus width, burst length and timing.

---
 rtl/rom_burst_reader_if.sv | 42 ++++
 rtl/rom_burst_reader.sv | 203 ++++++++++++++++++++
 tb/tb_rom_burst_reader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_burst_reader_if.sv
// Request / beat-stream / external ROM bus of rom_burst_reader.
// data_ready_in is present only when ROM_STALL_EN is defined.
interface rom_burst_reader_if #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned MAX_BURST = 16
);
  localparam int unsigned NPHASE  = (ADDR_W + BUS_W - 1) / BUS_W;
  localparam int unsigned LATCH_N = (NPHASE > 1) ? NPHASE - 1 : 1;
  localparam int unsigned LEN_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic               req_valid_in;
  logic               req_ready_out;
  logic [ADDR_W-1:0]  req_addr_in;
  logic [LEN_W-1:0]   req_len_in;
  logic [BUS_W-1:0]   data_in;
  logic [BUS_W-1:0]   addr_out;
  logic [LATCH_N-1:0] latch_out;
  logic               data_valid_out;
  logic [BUS_W-1:0]   data_out;
  logic               last_out;
  logic               busy_out;
`ifdef ROM_STALL_EN
  logic               data_ready_in;
`endif

  modport slave (
    input  req_valid_in, req_addr_in, req_len_in, data_in,
`ifdef ROM_STALL_EN
    input  data_ready_in,
`endif
    output req_ready_out, addr_out, latch_out, data_valid_out, data_out, last_out, busy_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_len_in, data_in,
`ifdef ROM_STALL_EN
    output data_ready_in,
`endif
    input  req_ready_out, addr_out, latch_out, data_valid_out, data_out, last_out, busy_out
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst reader for a parallel ROM with address chunks latched off a shared bus.
// Optional macro ROM_STALL_EN adds data_ready_in back-pressure on the beat output.
module rom_burst_reader #(
  parameter int unsigned PERIOD_NS = 10,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned SETUP_NS  = 50,
  parameter int unsigned HOLD_NS   = 5,
  parameter int unsigned ACCESS_NS = 250,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  rom_burst_reader_if.slave   bus
);
  localparam int unsigned NPHASE     = (ADDR_W + BUS_W - 1) / BUS_W;
  localparam int unsigned LATCH_N    = (NPHASE > 1) ? NPHASE - 1 : 1;
  localparam int unsigned LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned PAD_W      = NPHASE * BUS_W;
  localparam int unsigned KW         = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam int unsigned SETUP_RAW  = (SETUP_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int unsigned HOLD_RAW   = (HOLD_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int unsigned ACCESS_RAW = (ACCESS_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int unsigned SETUP_CYC  = (SETUP_RAW > 0) ? SETUP_RAW : 1;
  localparam int unsigned HOLD_CYC   = (HOLD_RAW > 0) ? HOLD_RAW : 1;
  localparam int unsigned ACCESS_CYC = (ACCESS_RAW > 0) ? ACCESS_RAW : 1;
  localparam int unsigned CNT_MAX0   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CNT_MAX    = (CNT_MAX0 > ACCESS_CYC) ? CNT_MAX0 : ACCESS_CYC;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [BUS_W-1:0]   bus_addr_q, bus_addr_d;
  logic [LATCH_N-1:0] latch_q, latch_d;
  logic               valid_q, valid_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               start_next;
  logic [ADDR_W-1:0]  addr_inc;

  // Chunk k of the address, zero-padded above ADDR_W.
  function automatic logic [BUS_W-1:0] chunk_of(input logic [ADDR_W-1:0] a, input int unsigned k);
    logic [PAD_W-1:0] p;
    p = PAD_W'(a);
    return p[k*BUS_W +: BUS_W];
  endfunction

  assign addr_inc = addr_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    bus_addr_d = bus_addr_q;
    latch_d    = '0;
    data_d     = data_q;
    start_next = 1'b0;
`ifdef ROM_STALL_EN
    valid_d    = valid_q;
    last_d     = last_q;
`else
    valid_d    = 1'b0;
    last_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_in && ready_q) begin
          addr_d     = bus.req_addr_in;
          rem_d      = bus.req_len_in;
          k_d        = '0;
          bus_addr_d = chunk_of(bus.req_addr_in, 0);
          if (NPHASE == 1) begin
            state_d = S_WAIT;
            cnt_d   = CW'(ACCESS_CYC - 1);
          end else begin
            state_d = S_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          latch_d = LATCH_N'(1) << k_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        state_d = S_HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (32'(k_q) + 32'd2 < NPHASE) begin
          k_d        = k_q + KW'(1);
          bus_addr_d = chunk_of(addr_q, 32'(k_q) + 32'd1);
          state_d    = S_SETUP;
          cnt_d      = CW'(SETUP_CYC - 1);
        end else begin
          bus_addr_d = chunk_of(addr_q, NPHASE - 1);
          state_d    = S_WAIT;
          cnt_d      = CW'(ACCESS_CYC - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
`ifdef ROM_STALL_EN
          // Capture once, then hold the beat until the consumer accepts it.
          if (!valid_q) begin
            data_d  = bus.data_in;
            valid_d = 1'b1;
            last_d  = (rem_q == '0);
          end else if (bus.data_ready_in) begin
            valid_d    = 1'b0;
            last_d     = 1'b0;
            start_next = 1'b1;
          end
`else
          data_d     = bus.data_in;
          valid_d    = 1'b1;
          last_d     = (rem_q == '0);
          start_next = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Following beat restarts the address sequence on the same edge.
    if (start_next) begin
      if (rem_q == '0) begin
        state_d = S_IDLE;
      end else begin
        rem_d      = rem_q - LEN_W'(1);
        addr_d     = addr_inc;
        k_d        = '0;
        bus_addr_d = chunk_of(addr_inc, 0);
        if (NPHASE == 1) begin
          state_d = S_WAIT;
          cnt_d   = CW'(ACCESS_CYC - 1);
        end else begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      bus_addr_q <= '0;
      latch_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      bus_addr_q <= bus_addr_d;
      latch_q    <= latch_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready_out  = ready_q;
  assign bus.busy_out       = busy_q;
  assign bus.addr_out       = bus_addr_q;
  assign bus.latch_out      = latch_q;
  assign bus.data_valid_out = valid_q;
  assign bus.data_out       = data_q;
  assign bus.last_out       = last_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: default, three-phase and 20 ns-period builds.
// Exercises the ROM_STALL_EN back-pressure path when that macro is defined.
module tb_rom_burst_reader;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

`ifdef ROM_STALL_EN
  localparam int BEAT_GAP = 33;
`else
  localparam int BEAT_GAP = 32;
`endif

  always #5 clk = ~clk;

  rom_burst_reader_if #(.ADDR_W(16), .BUS_W(8), .MAX_BURST(16)) ia ();
  rom_burst_reader_if #(.ADDR_W(20), .BUS_W(8), .MAX_BURST(16)) ib ();
  rom_burst_reader_if #(.ADDR_W(16), .BUS_W(8), .MAX_BURST(16)) ic ();

  rom_burst_reader #(.PERIOD_NS(10), .ADDR_W(16), .BUS_W(8), .SETUP_NS(50), .HOLD_NS(5),
                     .ACCESS_NS(250), .MAX_BURST(16)) dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(ia));
  rom_burst_reader #(.PERIOD_NS(10), .ADDR_W(20), .BUS_W(8), .SETUP_NS(50), .HOLD_NS(5),
                     .ACCESS_NS(250), .MAX_BURST(16)) dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(ib));
  rom_burst_reader #(.PERIOD_NS(20), .ADDR_W(16), .BUS_W(8), .SETUP_NS(50), .HOLD_NS(5),
                     .ACCESS_NS(250), .MAX_BURST(16)) dut_c (.clk_in(clk), .rst_n_in(rst_n), .bus(ic));

  // External latches and ROM: data = XOR of all address chunks (^ 0xE3 for 16-bit ROMs).
  logic [7:0] la, lb0, lb1, lc;
  always @(posedge clk) begin
    if (ia.latch_out[0]) la  <= ia.addr_out;
    if (ib.latch_out[0]) lb0 <= ib.addr_out;
    if (ib.latch_out[1]) lb1 <= ib.addr_out;
    if (ic.latch_out[0]) lc  <= ic.addr_out;
  end
  assign ia.data_in = la ^ ia.addr_out ^ 8'hE3;
  assign ib.data_in = lb0 ^ lb1 ^ ib.addr_out;
  assign ic.data_in = lc ^ ic.addr_out ^ 8'hE3;

  task automatic start_a(input logic [15:0] a, input logic [3:0] l);
    int t = 0;
    @(negedge clk);
    while (ia.req_ready_out !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    tests++;
    if (ia.req_ready_out !== 1'b1) begin fails++; $display("FAIL start_a_ready got %b want 1", ia.req_ready_out); end
    ia.req_valid_in = 1'b1; ia.req_addr_in = a; ia.req_len_in = l;
    @(negedge clk);
    ia.req_valid_in = 1'b0;
  endtask

  task automatic start_b(input logic [19:0] a);
    int t = 0;
    @(negedge clk);
    while (ib.req_ready_out !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    tests++;
    if (ib.req_ready_out !== 1'b1) begin fails++; $display("FAIL start_b_ready got %b want 1", ib.req_ready_out); end
    ib.req_valid_in = 1'b1; ib.req_addr_in = a; ib.req_len_in = 4'd0;
    @(negedge clk);
    ib.req_valid_in = 1'b0;
  endtask

  task automatic start_c(input logic [15:0] a);
    int t = 0;
    @(negedge clk);
    while (ic.req_ready_out !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    tests++;
    if (ic.req_ready_out !== 1'b1) begin fails++; $display("FAIL start_c_ready got %b want 1", ic.req_ready_out); end
    ic.req_valid_in = 1'b1; ic.req_addr_in = a; ic.req_len_in = 4'd0;
    @(negedge clk);
    ic.req_valid_in = 1'b0;
  endtask

  // Counts negedges until ia.data_valid_out; cyc = -1 if it never rises within maxc.
  task automatic wait_valid_a(input int maxc, output int cyc, output logic [7:0] d, output logic l);
    cyc = -1; d = '0; l = 1'b0;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if (ia.data_valid_out === 1'b1) begin cyc = n; d = ia.data_out; l = ia.last_out; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ia.req_ready_out, ia.busy_out, ia.data_valid_out, ia.last_out} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {ia.req_ready_out, ia.busy_out, ia.data_valid_out, ia.last_out});
    end
    tests++;
    if ({ia.addr_out, ia.latch_out, ia.data_out} !== 17'h0) begin
      fails++; $display("FAIL reset_buses got %h want 0", {ia.addr_out, ia.latch_out, ia.data_out});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({ia.req_ready_out, ib.req_ready_out, ic.req_ready_out, ia.busy_out} !== 4'b1110) begin
      fails++; $display("FAIL reset_release_ready got %b want 1110", {ia.req_ready_out, ib.req_ready_out, ic.req_ready_out, ia.busy_out});
    end
  endtask

  task automatic test_single_read;
    int lat_cyc = -1, lat_cnt = 0, val_cyc = -1;
    logic [7:0] addr7 = '0, dat = '0;
    logic lst = 1'b0;
    start_a(16'h12AB, 4'd0);
    tests++;
    if ({ia.addr_out, ia.busy_out, ia.req_ready_out} !== {8'hAB, 2'b10}) begin
      fails++; $display("FAIL single_accept got addr=%h busy=%b ready=%b want AB 1 0", ia.addr_out, ia.busy_out, ia.req_ready_out);
    end
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (ia.latch_out !== '0) begin lat_cnt++; if (lat_cyc < 0) lat_cyc = n; end
      if (n == 7) addr7 = ia.addr_out;
      if (ia.data_valid_out === 1'b1 && val_cyc < 0) begin val_cyc = n; dat = ia.data_out; lst = ia.last_out; end
    end
    tests++;
    if (lat_cyc != 5 || lat_cnt != 1) begin fails++; $display("FAIL single_latch got edge=%0d pulses=%0d want 5 1", lat_cyc, lat_cnt); end
    tests++;
    if (addr7 !== 8'h12) begin fails++; $display("FAIL single_final_chunk got %h want 12", addr7); end
    tests++;
    if (val_cyc != 32) begin fails++; $display("FAIL single_latency got %0d want 32", val_cyc); end
    tests++;
    if (dat !== 8'h5A || lst !== 1'b1) begin fails++; $display("FAIL single_data got %h last=%b want 5A 1", dat, lst); end
    tests++;
    if (ia.data_valid_out !== 1'b0 || ia.data_out !== 8'h5A) begin
      fails++; $display("FAIL single_hold got valid=%b data=%h want 0 5A", ia.data_valid_out, ia.data_out);
    end
  endtask

  task automatic test_burst_wrap;
    logic [7:0] exp_d [4] = '{8'hE2, 8'hE3, 8'hE3, 8'hE2};
    int cyc;
    logic [7:0] d;
    logic l;
    start_a(16'hFFFE, 4'd3);
    repeat (10) @(negedge clk);
    ia.req_valid_in = 1'b1; ia.req_addr_in = 16'h0000; ia.req_len_in = 4'd0;
    tests++;
    if (ia.req_ready_out !== 1'b0) begin fails++; $display("FAIL busy_ignores_req got ready=%b want 0", ia.req_ready_out); end
    @(negedge clk);
    ia.req_valid_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wait_valid_a(60, cyc, d, l);
      tests++;
      if (cyc != ((b == 0) ? 21 : BEAT_GAP)) begin
        fails++; $display("FAIL wrap_gap beat%0d got %0d want %0d", b, cyc, (b == 0) ? 21 : BEAT_GAP);
      end
      tests++;
      if (d !== exp_d[b]) begin fails++; $display("FAIL wrap_data beat%0d got %h want %h", b, d, exp_d[b]); end
      tests++;
      if (l !== (b == 3)) begin fails++; $display("FAIL wrap_last beat%0d got %b want %b", b, l, b == 3); end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (ia.req_ready_out !== 1'b1 || ia.busy_out !== 1'b0) begin
      fails++; $display("FAIL wrap_idle got ready=%b busy=%b want 1 0", ia.req_ready_out, ia.busy_out);
    end
  endtask

  task automatic test_reset_mid_burst;
    int cyc, bad = 0;
    logic [7:0] d;
    logic l;
    start_a(16'h0040, 4'd3);
    repeat (50) @(negedge clk);
    tests++;
    if (ia.busy_out !== 1'b1 || ia.data_out !== 8'hA3) begin
      fails++; $display("FAIL midburst_state got busy=%b data=%h want 1 A3", ia.busy_out, ia.data_out);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ia.req_ready_out, ia.busy_out, ia.data_valid_out, ia.last_out, ia.latch_out, ia.addr_out, ia.data_out} !== 21'h0) begin
      fails++; $display("FAIL midburst_async_clear got %h want 0",
                        {ia.req_ready_out, ia.busy_out, ia.data_valid_out, ia.last_out, ia.latch_out, ia.addr_out, ia.data_out});
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (ia.latch_out !== '0 || ia.data_valid_out !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL midburst_quiet got %0d active cycles want 0", bad); end
    rst_n = 1'b1;
    start_a(16'h0102, 4'd0);
    wait_valid_a(40, cyc, d, l);
    tests++;
    if (cyc != 32 || d !== 8'hE0 || l !== 1'b1) begin
      fails++; $display("FAIL post_reset_read got cyc=%0d data=%h last=%b want 32 E0 1", cyc, d, l);
    end
  endtask

  task automatic test_three_phase;
    int l0 = -1, l1 = -1, val_cyc = -1, overlap = 0;
    logic [7:0] a0 = '0, a1 = '0, af = '0, dat = '0;
    start_b(20'hABCDE);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (ib.latch_out === 2'b11) overlap++;
      if (ib.latch_out === 2'b01 && l0 < 0) begin l0 = n; a0 = ib.addr_out; end
      if (ib.latch_out === 2'b10 && l1 < 0) begin l1 = n; a1 = ib.addr_out; end
      if (ib.data_valid_out === 1'b1 && val_cyc < 0) begin val_cyc = n; dat = ib.data_out; af = ib.addr_out; end
    end
    tests++;
    if (l0 != 5 || a0 !== 8'hDE) begin fails++; $display("FAIL three_latch0 got edge=%0d addr=%h want 5 DE", l0, a0); end
    tests++;
    if (l1 != 12 || a1 !== 8'hBC) begin fails++; $display("FAIL three_latch1 got edge=%0d addr=%h want 12 BC", l1, a1); end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL three_overlap got %0d want 0", overlap); end
    tests++;
    if (val_cyc != 39 || dat !== 8'h68 || af !== 8'h0A) begin
      fails++; $display("FAIL three_data got cyc=%0d data=%h addr=%h want 39 68 0A", val_cyc, dat, af);
    end
  endtask

  task automatic test_timing_scale;
    int lat_cyc = -1, val_cyc = -1;
    logic [7:0] dat = '0;
    start_c(16'h12AB);
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (ic.latch_out !== '0 && lat_cyc < 0) lat_cyc = n;
      if (ic.data_valid_out === 1'b1 && val_cyc < 0) begin val_cyc = n; dat = ic.data_out; end
    end
    tests++;
    if (lat_cyc != 3) begin fails++; $display("FAIL scale_latch got %0d want 3", lat_cyc); end
    tests++;
    if (val_cyc != 18 || dat !== 8'h5A) begin fails++; $display("FAIL scale_data got cyc=%0d data=%h want 18 5A", val_cyc, dat); end
  endtask

`ifdef ROM_STALL_EN
  task automatic test_stall;
    int cyc, bad = 0;
    logic [7:0] d;
    logic l;
    ia.data_ready_in = 1'b0;
    start_a(16'h1000, 4'd1);
    wait_valid_a(40, cyc, d, l);
    tests++;
    if (cyc != 32 || d !== 8'hF3 || l !== 1'b0) begin
      fails++; $display("FAIL stall_beat1 got cyc=%0d data=%h last=%b want 32 F3 0", cyc, d, l);
    end
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      if (ia.data_valid_out !== 1'b1 || ia.data_out !== 8'hF3 || ia.latch_out !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    ia.data_ready_in = 1'b1;
    @(negedge clk);
    tests++;
    if (ia.data_valid_out !== 1'b0 || ia.busy_out !== 1'b1) begin
      fails++; $display("FAIL stall_handshake got valid=%b busy=%b want 0 1", ia.data_valid_out, ia.busy_out);
    end
    wait_valid_a(40, cyc, d, l);
    tests++;
    if (cyc != 32 || d !== 8'hF2 || l !== 1'b1) begin
      fails++; $display("FAIL stall_beat2 got cyc=%0d data=%h last=%b want 32 F2 1", cyc, d, l);
    end
  endtask
`endif

  initial begin
    ia.req_valid_in = 1'b0; ia.req_addr_in = '0; ia.req_len_in = '0;
    ib.req_valid_in = 1'b0; ib.req_addr_in = '0; ib.req_len_in = '0;
    ic.req_valid_in = 1'b0; ic.req_addr_in = '0; ic.req_len_in = '0;
`ifdef ROM_STALL_EN
    ia.data_ready_in = 1'b1; ib.data_ready_in = 1'b1; ic.data_ready_in = 1'b1;
`endif
    test_reset();
    test_single_read();
    test_burst_wrap();
    test_reset_mid_burst();
    test_three_phase();
    test_timing_scale();
`ifdef ROM_STALL_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
